// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative radix-2 multiply/divide unit with HI/LO registers for schoolMIPS.
// Define SM_MULDIV_FAST_MUL_EN to compute MULT/MULTU in one pass instead of iterating.
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT             state, stateNext;
  logic              loadOp, finish;
  logic [CW-1:0]     counter;
  logic [W2-1:0]     acc;
  logic [WIDTH-1:0]  aMag, bMag, aRaw;
  logic              isDiv, negRes, negRem;
  logic              aNeg, bNeg;
  logic [WIDTH-1:0]  aAbs, bAbs;
  logic [WIDTH:0]    mulSum, divTrial;
  logic [W2-1:0]     mulNext, divNext, mulMag, product;
  logic [WIDTH-1:0]  quot, rem, resHi, resLo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // flush beats start in IDLE and aborts RUN/FIX without a result write
  always_comb begin
    stateNext = state;
    loadOp    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          loadOp    = 1'b1;
          stateNext = RUN;
`ifdef SM_MULDIV_FAST_MUL_EN
          if (!op[1]) stateNext = FIX;
`endif
        end
      end
      RUN: begin
        if (flush)              stateNext = IDLE;
        else if (counter == '0) stateNext = FIX;
      end
      FIX: begin
        stateNext = IDLE;
        finish    = !flush;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    aNeg = op[0] & srcA[WIDTH-1];
    bNeg = op[0] & srcB[WIDTH-1];
    aAbs = aNeg ? -srcA : srcA;
    bAbs = bNeg ? -srcB : srcB;
  end

  // Multiply: multiplier sits in the low half and shifts out as the sum shifts in
  assign mulSum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, aMag} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Divide: partial remainder in the high half, quotient bits enter at the bottom
  assign divTrial = acc[W2-1:WIDTH-1] - {1'b0, bMag};
  assign divNext  = divTrial[WIDTH] ? {acc[W2-2:0], 1'b0}
                                    : {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef SM_MULDIV_FAST_MUL_EN
  assign mulMag = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
`else
  assign mulMag = acc;
`endif

  always_comb begin
    product = negRes ? -mulMag : mulMag;
    quot    = acc[WIDTH-1:0];
    rem     = acc[W2-1:WIDTH];
    resHi   = product[W2-1:WIDTH];
    resLo   = product[WIDTH-1:0];
    if (isDiv) begin
      if (bMag == '0) begin
        resHi = aRaw;
        resLo = '1;
      end else begin
        resHi = negRem ? -rem : rem;
        resLo = negRes ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      acc     <= '0;
      aMag    <= '0;
      bMag    <= '0;
      aRaw    <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (loadOp) begin
        counter <= CW'(WIDTH - 1);
        aMag    <= aAbs;
        bMag    <= bAbs;
        aRaw    <= srcA;
        isDiv   <= op[1];
        negRes  <= aNeg ^ bNeg;
        negRem  <= aNeg;
        acc     <= op[1] ? {{WIDTH{1'b0}}, aAbs} : {{WIDTH{1'b0}}, bAbs};
      end else if (state == RUN) begin
        counter <= counter - 1'b1;
        acc     <= isDiv ? divNext : mulNext;
      end
      // A move-to in IDLE lands even on a start edge; the later result overwrites it
      if (finish) begin
        hi <= resHi;
        lo <= resLo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
